mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: clk input 1 is the clock, with all state changing on its rising edge; reset input 1 is the asynchronous, active-high reset.
REQ-002 The instruction port SHALL be: i_address input 32 (byte address); i_read input 1; i_readdata output 32; i_waitrequest output 1.
REQ-003 The data port SHALL be: d_address input 32 (byte address); d_read input 1; d_write input 1; d_byteenable input 4; d_writedata input 32; d_readdata output 32; d_waitrequest output 1.
REQ-004 The memory port SHALL be: mem_address output 12 (word address); mem_read output 1; mem_write output 1; mem_byteenable output 4; mem_writedata output 32; mem_readdata input 32 (registered, valid 1 cycle after mem_read).

Function
REQ-005 The FSM SHALL have three states: IDLE, ISSUE and DONE.
REQ-006 In IDLE with at least one request pending, the arbiter SHALL latch the winner (port, word address = address[13:2], op, byteenable, writedata) and go to ISSUE; address bits [31:14] are ignored, so addresses wrap modulo 16 KiB.
REQ-007 In IDLE with no request, the arbiter SHALL remain in IDLE.
REQ-008 In ISSUE, the arbiter SHALL drive mem_read or mem_write high for exactly 1 cycle with the latched fields, then go to DONE.
REQ-009 mem_read and mem_write SHALL be 0 in every state other than ISSUE.
REQ-010 In DONE, the granted port's waitrequest SHALL be 0 for exactly 1 cycle, its readdata SHALL equal mem_readdata (reads), and the FSM SHALL return to IDLE.
REQ-011 Fixed latency: a request first seen in IDLE at cycle N SHALL complete with waitrequest=0 in cycle N+2; a back-to-back request SHALL be re-arbitrated in the IDLE cycle that follows DONE.
REQ-012 x_waitrequest SHALL equal (x request asserted) AND NOT (state==DONE AND grant==x); with no request asserted, waitrequest SHALL be 0.
REQ-013 Requesters hold all inputs stable while waitrequest=1; the arbiter uses only the latched copies after IDLE.
REQ-014 d_read and d_write both high SHALL be treated as a write.
REQ-015 A write SHALL return d_readdata = 0.
REQ-016 i_readdata and d_readdata SHALL be 0 whenever the port is not in its DONE cycle.
REQ-017 When the instruction and data ports request simultaneously, the data port SHALL win (default policy; see REQ-022).
REQ-018 The losing port SHALL keep waitrequest=1 and SHALL be served in the next arbitration; no request is ever dropped.

Reset
REQ-019 Assertion of reset SHALL immediately force: state=IDLE, mem_read=0, mem_write=0, mem_address=0, mem_byteenable=0, mem_writedata=0, readdata outputs=0, and last_grant=INSTR.
REQ-020 A transaction in progress when reset asserts SHALL be abandoned, with no memory write occurring after reset assertion.
REQ-021 While reset is high, both waitrequest outputs SHALL be 1 if the corresponding request is asserted.

Configuration
REQ-022 With macro MEM_ARBITER_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port opposite last_grant, and last_grant SHALL update at every IDLE->ISSUE transition; the first tie after reset goes to the data port.
REQ-023 Without MEM_ARBITER_ROUND_ROBIN_EN, the data port SHALL always win ties, and last_grant SHALL be absent or unused.

Verification
REQ-024 Single instruction fetch: i_read=1 with i_address=0x00000010, mem word 4 = 0x8C020004 -> i_waitrequest=1, 1, 0 over cycles N..N+2; i_readdata=0x8C020004 at N+2; exactly one mem_read pulse with mem_address=4.
REQ-025 Byte write then read: d_write with d_address=0x20, d_byteenable=4'b0001, d_writedata=0x000000AB onto word 8 = 0x11223344 -> d_read of 0x20 returns 0x112233AB, with d_waitrequest low at N+2 for each access.
REQ-026 Simultaneous requests, default build: i_read at 0x0 and d_read at 0x4 in the same cycle -> data completes at N+2 and instruction at N+5, the instruction port holding waitrequest=1 throughout.
REQ-027 Round-robin build: both ports requesting continuously for 4 transactions -> grant order D, I, D, I.
REQ-028 Reset during ISSUE of a d_write to 0x40 -> mem_write drops asynchronously, word 16 is unchanged, the FSM is in IDLE, and a subsequent i_read completes in 2 cycles.
REQ-029 Address wrap: d_read at 0x00004008 -> mem_address=2, returning the same data as d_read at 0x8.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-port (instruction / data) arbiter onto a single-ported
//             word-addressed memory with fixed IDLE -> ISSUE -> DONE latency.
//  Options  : MEM_ARBITER_ROUND_ROBIN_EN -- when defined, simultaneous
//             requests alternate between ports (first tie goes to data);
//             when undefined, the data port always wins ties.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  // instruction port
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic [31:0] i_readdata,
  output logic        i_waitrequest,
  // data port
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byteenable,
  input  logic [31:0] d_writedata,
  output logic [31:0] d_readdata,
  output logic        d_waitrequest,
  // memory port
  output logic [11:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic GRANT_INSTR = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  // FSM state and the latched copy of the winning request
  logic [1:0]  state_q, state_d;
  logic        grant_q, grant_d;
  logic [11:0] addr_q,  addr_d;
  logic        wr_q,    wr_d;
  logic [3:0]  be_q,    be_d;
  logic [31:0] wdata_q, wdata_d;

  logic w_i_req;
  logic w_d_req;
  logic w_tie_data;
  logic w_win_data;
  logic w_done_i;
  logic w_done_d;

  // Only the word-address bits within 16 KiB are meaningful; the rest wrap.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{i_address[31:14], i_address[1:0],
                                d_address[31:14], d_address[1:0]};

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  // A tie goes to whichever port was not granted most recently.
  assign w_tie_data = (last_grant_q == GRANT_INSTR);

  // Remember the most recent grant; it only changes when a request is accepted.
  always_comb begin
    last_grant_d = last_grant_q;
    if ((state_q == S_IDLE) && (w_i_req || w_d_req)) begin
      last_grant_d = w_win_data;
    end
  end

  // last_grant register; resets to INSTR so the first tie goes to data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= GRANT_INSTR;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Fixed priority: the data port always wins a tie.
  assign w_tie_data = 1'b1;
`endif

  assign w_win_data = w_d_req && (!w_i_req || w_tie_data);

  // State register plus the latched request fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= GRANT_INSTR;
      addr_q  <= 12'd0;
      wr_q    <= 1'b0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state: arbitrate and capture in IDLE, then step through ISSUE and DONE
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (w_i_req || w_d_req) begin
          state_d = S_ISSUE;
          if (w_win_data) begin
            grant_d = GRANT_DATA;
            addr_d  = d_address[13:2];
            wr_d    = d_write;            // read+write together counts as write
            be_d    = d_byteenable;
            wdata_d = d_writedata;
          end else begin
            grant_d = GRANT_INSTR;
            addr_d  = i_address[13:2];
            wr_d    = 1'b0;
            be_d    = 4'hF;
            wdata_d = 32'd0;
          end
        end
      end
      S_ISSUE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign w_done_i = (state_q == S_DONE) && (grant_q == GRANT_INSTR);
  assign w_done_d = (state_q == S_DONE) && (grant_q == GRANT_DATA);

  // Outputs: one-cycle memory strobe in ISSUE, one-cycle completion in DONE
  always_comb begin
    mem_read       = (state_q == S_ISSUE) && !wr_q;
    mem_write      = (state_q == S_ISSUE) &&  wr_q;
    mem_address    = addr_q;
    mem_byteenable = be_q;
    mem_writedata  = wdata_q;
    i_readdata     = w_done_i ? mem_readdata : 32'd0;
    d_readdata     = (w_done_d && !wr_q) ? mem_readdata : 32'd0;
    i_waitrequest  = w_i_req && !w_done_i;
    d_waitrequest  = w_d_req && !w_done_d;
  end

endmodule
`default_nettype wire
